pwm_duty_ramp: RTL and testbench
================================

Name: pwm_duty_ramp

Overview:
- Slew-rate controller that sequences the 11-bit duty input of the PWM11 generator.
- Accepts a target duty over a valid/ready handshake and steps the applied duty toward it by at most STEP counts per ramp step.
- Duty changes only on PWM period boundaries (2048-clock frame), so no glitched or truncated pulses.
- Provides soft-start on enable and soft-stop to 0 on disable; sits between motor/LED control logic and PWM11.

Parameters:
- STEP, 16, maximum duty change per ramp step (1..2047).
- PERIODS_PER_STEP, 1, number of PWM periods between ramp steps (1..255).

Ports:
- clk  input  1  system clock, shared with PWM11
- rst  input  1  synchronous active-high reset
- en  input  1  level; 1 = run toward accepted target, 0 = soft-stop to duty 0
- tgt_duty  input  11  requested duty, unsigned
- tgt_vld  input  1  tgt_duty valid
- tgt_rdy  output  1  target can be accepted this cycle
- duty  output  11  applied duty, drives PWM11 duty
- period_start  output  1  1-cycle strobe in last clock of each PWM period (cnt==2047)
- ramping  output  1  applied duty differs from effective target
- off  output  1  controller in OFF state (duty==0, disabled)

Behaviour:
- Internal 11-bit period counter cnt: 0 on reset, +1 every clk, wraps 2047->0. It is aligned with PWM11's counter when both leave reset in the same cycle; system integration guarantees this.
- period_start = (cnt==2047), combinational from the cnt register.
- Boundary: a cycle with period_start=1. Internal skip counter (8-bit) counts boundaries. A step boundary occurs when skip==PERIODS_PER_STEP-1; skip then clears to 0, otherwise skip increments.
- The duty register updates only on step boundaries. The new value is visible from the cycle where cnt==0.
- Handshake: a transfer occurs when tgt_vld && tgt_rdy. On transfer, the target register is set to tgt_duty. tgt_rdy = en && state!=STOP. The target register is held when no transfer occurs.
- Effective target eff = en ? target : 0.
- Step arithmetic is done at 12 bits to avoid wrap:
  - if duty < eff: duty <= min(duty+STEP, eff)
  - if duty > eff: duty <= (duty-eff > STEP) ? duty-STEP : eff
- States:
  - OFF: duty==0, en==0. Go to IDLE when en=1.
  - IDLE: duty==eff. Go to RAMP when duty!=eff. Go to STOP when en=0 and duty!=0. Go to OFF when en=0 and duty==0.
  - RAMP: stepping. Go to IDLE on the step boundary that reaches eff. Go to STOP when en falls.
  - STOP: stepping toward 0. Go to OFF on the step boundary that reaches 0. Go to RAMP if en rises before duty reaches 0; the target register is retained.
- ramping = (state==RAMP || state==STOP). off = (state==OFF).
- Simultaneous transfer and step boundary in one cycle: the step uses the old target; the new target applies from the next step boundary.
- Target changes mid-ramp, including a direction reversal, are legal. The next step moves toward the new target.
- A transfer of a target equal to the current duty keeps or returns the state to IDLE with no duty change.
- Reset values: cnt=0, skip=0, target=0, duty=0, state=OFF, tgt_rdy=0, period_start=0, ramping=0, off=1.
- Reset asserted mid-ramp: all state returns to reset values on the next clk edge. duty goes to 0 immediately, with no soft-stop.
- en toggled within one period with no step boundary: no duty change.

Test Plan:
- Reset, en=1, transfer tgt_duty=100 (STEP=16, PERIODS_PER_STEP=1):
  - Required: duty 0->16->32->...->96->100 on successive boundaries, 7 steps.
  - Required: each change first visible at cnt==0.
  - Required: ramping deasserts with the 100 update; then IDLE.
- From duty=100, drop en:
  - Required: tgt_rdy=0 in the same cycle en drops.
  - Required: duty 84,68,...,4,0 on successive boundaries.
  - Required: off=1 after the boundary that reaches 0; target still 100.
  - Then re-raise en: duty ramps back to 100.
- tgt_vld pulsed in the same cycle as period_start (cnt==2047), duty=32, old target 64, new target 40:
  - Required: duty goes to 48 at this boundary, then 40 at the next.
- PERIODS_PER_STEP=4, target 2047 from 0, STEP=2047:
  - Required: duty is 2047 after the 4th boundary and unchanged before it.
  - Required: no 12-bit wrap or overshoot; 2047-step down then reaches 0 exactly.
- Assert rst while ramping at duty=48 toward 200:
  - Required: next cycle duty=0, cnt=0, off=1, tgt_rdy=0, target=0.
- Hold tgt_vld=1 with en=0:
  - Required: no transfer and target unchanged.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter for the PWM11 duty input: moves the applied duty toward the
// accepted target by at most STEP counts, changing it only at PWM frame boundaries.
module pwm_duty_ramp #(
    parameter int unsigned STEP             = 16,
    parameter int unsigned PERIODS_PER_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] tgt_duty,
    input  logic        tgt_vld,
    output logic        tgt_rdy,
    output logic [10:0] duty,
    output logic        period_start,
    output logic        ramping,
    output logic        off
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_IDLE,
        ST_RAMP,
        ST_STOP
    } state_t;

    localparam logic [11:0] STEP12    = 12'(STEP);
    localparam logic [7:0]  SKIP_LAST = 8'(PERIODS_PER_STEP - 1);

    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  skip_q, skip_d;
    logic [10:0] target_q, target_d;
    logic [10:0] duty_q, duty_d;
    state_t      state_q, state_d;

    logic        step_b;
    logic        xfer;
    logic [10:0] eff;
    logic [11:0] duty12, eff12, sum12, diff12, dec12;
    logic [10:0] step_duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            skip_q   <= '0;
            target_q <= '0;
            duty_q   <= '0;
            state_q  <= ST_OFF;
        end else begin
            cnt_q    <= cnt_d;
            skip_q   <= skip_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            state_q  <= state_d;
        end
    end

    // Datapath: frame counter, boundary skipping, handshake and step arithmetic.
    always_comb begin
        period_start = (cnt_q == 11'h7FF);
        step_b       = period_start && (skip_q == SKIP_LAST);
        cnt_d        = cnt_q + 11'd1;
        skip_d       = skip_q;
        if (period_start) begin
            skip_d = step_b ? 8'd0 : skip_q + 8'd1;
        end

        tgt_rdy  = en && (state_q != ST_STOP);
        xfer     = tgt_vld && tgt_rdy;
        target_d = xfer ? tgt_duty : target_q;

        // Widened to 12 bits so duty+STEP and duty-STEP cannot wrap.
        eff       = en ? target_q : 11'd0;
        duty12    = {1'b0, duty_q};
        eff12     = {1'b0, eff};
        sum12     = duty12 + STEP12;
        diff12    = duty12 - eff12;
        dec12     = duty12 - STEP12;
        step_duty = duty_q;
        if (duty12 < eff12) begin
            step_duty = (sum12 > eff12) ? eff : sum12[10:0];
        end else if (duty12 > eff12) begin
            step_duty = (diff12 > STEP12) ? dec12[10:0] : eff;
        end
        duty_d = step_b ? step_duty : duty_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!en) begin
                    state_d = (duty_q != 11'd0) ? ST_STOP : ST_OFF;
                end else if (duty_d != eff) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (!en) begin
                    state_d = ST_STOP;
                end else if (duty_d == eff) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STOP: begin
                if (en) begin
                    state_d = ST_RAMP;
                end else if (step_b && (duty_d == 11'd0)) begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    assign duty    = duty_q;
    assign ramping = (state_q == ST_RAMP) || (state_q == ST_STOP);
    assign off     = (state_q == ST_OFF);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed stimulus pushes expected per-boundary duty
// values into queues; monitors compare them at each PWM frame boundary.
module tb_pwm_duty_ramp;

    logic        clk = 1'b0;
    logic        rst_a, en_a, vld_a, rdy_a, ps_a, ramp_a, off_a;
    logic [10:0] tgt_a, duty_a;
    logic        rst_b, en_b, vld_b, rdy_b, ps_b, ramp_b, off_b;
    logic [10:0] tgt_b, duty_b;

    always #5 clk = ~clk;

    pwm_duty_ramp #(.STEP(16), .PERIODS_PER_STEP(1)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .tgt_duty(tgt_a), .tgt_vld(vld_a),
        .tgt_rdy(rdy_a), .duty(duty_a), .period_start(ps_a), .ramping(ramp_a),
        .off(off_a)
    );

    pwm_duty_ramp #(.STEP(2047), .PERIODS_PER_STEP(4)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .tgt_duty(tgt_b), .tgt_vld(vld_b),
        .tgt_rdy(rdy_b), .duty(duty_b), .period_start(ps_b), .ramping(ramp_b),
        .off(off_b)
    );

    typedef struct {
        logic [10:0] prev;
        logic [10:0] nxt;
        logic        ramp;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   b_done = 0;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Monitor A: at cnt==2047 duty must still be the old value; at cnt==0 the new one.
    bit armed_a = 0;
    always @(negedge clk) begin
        exp_t e;
        if (armed_a) begin
            e = qa.pop_front();
            check("A duty after boundary", int'(duty_a), int'(e.nxt));
            check("A ramping after boundary", int'(ramp_a), int'(e.ramp));
            $display("A boundary: duty %0d -> %0d ramping %0d", e.prev, duty_a, ramp_a);
            armed_a = 0;
        end else if (ps_a && qa.size() > 0) begin
            check("A duty before boundary", int'(duty_a), int'(qa[0].prev));
            armed_a = 1;
        end
    end

    bit armed_b = 0;
    always @(negedge clk) begin
        exp_t e;
        if (armed_b) begin
            e = qb.pop_front();
            check("B duty after boundary", int'(duty_b), int'(e.nxt));
            check("B ramping after boundary", int'(ramp_b), int'(e.ramp));
            $display("B boundary: duty %0d -> %0d ramping %0d", e.prev, duty_b, ramp_b);
            armed_b = 0;
        end else if (ps_b && qb.size() > 0) begin
            check("B duty before boundary", int'(duty_b), int'(qb[0].prev));
            armed_b = 1;
        end
    end

    task automatic push_a(input logic [10:0] p, input logic [10:0] n, input logic r);
        exp_t e;
        e.prev = p; e.nxt = n; e.ramp = r;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [10:0] p, input logic [10:0] n, input logic r);
        exp_t e;
        e.prev = p; e.nxt = n; e.ramp = r;
        qb.push_back(e);
    endtask

    task automatic drain_a(input string name);
        int budget;
        budget = (qa.size() + 2) * 2048;
        while ((qa.size() > 0 || armed_a) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            check({name, " drain timeout"}, qa.size(), 0);
            qa.delete();
        end
    endtask

    task automatic drain_b(input string name);
        int budget;
        budget = (qb.size() + 2) * 4 * 2048;
        while ((qb.size() > 0 || armed_b) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            check({name, " drain timeout"}, qb.size(), 0);
            qb.delete();
        end
    endtask

    task automatic xfer_a(input logic [10:0] v);
        tgt_a = v;
        vld_a = 1'b1;
        #1;
        check("A tgt_rdy for transfer", int'(rdy_a), 1);
        @(negedge clk);
        vld_a = 1'b0;
        $display("A transfer target %0d", v);
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; vld_a = 1'b0; tgt_a = '0;
        repeat (5) @(negedge clk);
        check("A reset duty", int'(duty_a), 0);
        check("A reset off", int'(off_a), 1);
        check("A reset ramping", int'(ramp_a), 0);
        check("A reset tgt_rdy", int'(rdy_a), 0);
        check("A reset period_start", int'(ps_a), 0);
        rst_a = 1'b0;
        @(negedge clk);

        // Soft-start to 100.
        en_a = 1'b1;
        for (int i = 0; i < 6; i++) push_a(11'(16 * i), 11'(16 * (i + 1)), 1'b1);
        push_a(11'd96, 11'd100, 1'b0);
        xfer_a(11'd100);
        drain_a("ramp up");
        check("A off after ramp up", int'(off_a), 0);

        // Soft-stop: tgt_rdy drops with en.
        en_a = 1'b0;
        #1;
        check("A tgt_rdy on en drop", int'(rdy_a), 0);
        for (int i = 0; i < 6; i++) push_a(11'(100 - 16 * i), 11'(84 - 16 * i), 1'b1);
        push_a(11'd4, 11'd0, 1'b0);
        drain_a("soft stop");
        check("A off after soft stop", int'(off_a), 1);

        // Held valid while disabled must not transfer.
        tgt_a = 11'd500;
        vld_a = 1'b1;
        repeat (20) @(negedge clk);
        check("A tgt_rdy with en=0", int'(rdy_a), 0);
        vld_a = 1'b0;
        @(negedge clk);

        // Re-enable: retained target 100.
        en_a = 1'b1;
        for (int i = 0; i < 6; i++) push_a(11'(16 * i), 11'(16 * (i + 1)), 1'b1);
        push_a(11'd96, 11'd100, 1'b0);
        drain_a("restart");

        // en glitch inside one period: no change.
        en_a = 1'b0;
        repeat (10) @(negedge clk);
        en_a = 1'b1;
        push_a(11'd100, 11'd100, 1'b0);
        drain_a("en toggle");

        // Down-ramp via new target 32.
        for (int i = 0; i < 4; i++) push_a(11'(100 - 16 * i), 11'(84 - 16 * i), 1'b1);
        push_a(11'd36, 11'd32, 1'b0);
        xfer_a(11'd32);
        drain_a("ramp down");

        // Target 64, then 40 transferred on the boundary cycle itself.
        push_a(11'd32, 11'd48, 1'b1);
        push_a(11'd48, 11'd40, 1'b0);
        xfer_a(11'd64);
        begin
            int budget;
            budget = 2100;
            @(negedge clk);
            while (!ps_a && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check("A wait boundary for late transfer", int'(ps_a), 1);
            tgt_a = 11'd40;
            vld_a = 1'b1;
            @(negedge clk);
            vld_a = 1'b0;
        end
        drain_a("boundary transfer");

        // Reset while ramping at 48 toward 200.
        push_a(11'd40, 11'd48, 1'b0);
        xfer_a(11'd48);
        drain_a("to 48");
        xfer_a(11'd200);
        repeat (100) @(negedge clk);
        check("A duty before reset", int'(duty_a), 48);
        check("A ramping before reset", int'(ramp_a), 1);
        rst_a = 1'b1;
        en_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        check("A duty after mid-ramp reset", int'(duty_a), 0);
        check("A off after mid-ramp reset", int'(off_a), 1);
        check("A tgt_rdy after mid-ramp reset", int'(rdy_a), 0);
        check("A ramping after mid-ramp reset", int'(ramp_a), 0);
        begin
            int k;
            k = 0;
            while (!ps_a && k < 2100) begin
                @(negedge clk);
                k++;
            end
            check("A cycles from reset to period_start", k, 2047);
        end
        @(negedge clk);
        en_a = 1'b1;
        push_a(11'd0, 11'd0, 1'b0);
        drain_a("target cleared");

        begin
            int budget;
            budget = 100000;
            while (!b_done && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check("B completion", int'(b_done), 1);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Instance B: full-scale single step, four periods per step.
    initial begin
        rst_b = 1'b1; en_b = 1'b0; vld_b = 1'b0; tgt_b = '0;
        repeat (5) @(negedge clk);
        rst_b = 1'b0;
        en_b = 1'b1;
        tgt_b = 11'd2047;
        vld_b = 1'b1;
        for (int i = 0; i < 3; i++) push_b(11'd0, 11'd0, 1'b1);
        push_b(11'd0, 11'd2047, 1'b0);
        @(negedge clk);
        vld_b = 1'b0;
        $display("B transfer target 2047");
        drain_b("B up");
        tgt_b = 11'd0;
        vld_b = 1'b1;
        for (int i = 0; i < 3; i++) push_b(11'd2047, 11'd2047, 1'b1);
        push_b(11'd2047, 11'd0, 1'b0);
        @(negedge clk);
        vld_b = 1'b0;
        $display("B transfer target 0");
        drain_b("B down");
        check("B off while enabled at 0", int'(off_b), 0);
        check("B tgt_rdy while enabled", int'(rdy_b), 1);
        b_done = 1'b1;
    end

endmodule
